// File: rtl/cordic_iter_ctrl.sv
// Iteration sequencer for the iterative CORDIC datapath.
// It issues a load strobe, then N step cycles with the index, then a result handshake.
module cordic_iter_ctrl #(
  parameter int unsigned Iterations = 16,
  parameter int unsigned IdxWidth   = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [IdxWidth-1:0] n_i,
  output logic                ready_o,
  input  logic                abort_i,
  output logic                load_o,
  output logic                step_o,
  output logic [IdxWidth-1:0] iter_o,
  output logic                busy_o,
  output logic                valid_o,
  input  logic                ready_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [IdxWidth-1:0] MaxN   = IdxWidth'(Iterations);
  localparam logic [IdxWidth-1:0] IdxOne = IdxWidth'(1);
  localparam logic [IdxWidth-1:0] IdxZero = '0;

  state_t              state;
  logic [IdxWidth-1:0] nlat;
  logic [IdxWidth-1:0] n_clamped;

  // Requests above the datapath depth are clamped to the full depth.
  assign n_clamped = (n_i > MaxN) ? MaxN : n_i;

  // State, latched count and every output are registered together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      nlat    <= IdxZero;
      iter_o  <= IdxZero;
      load_o  <= 1'b0;
      step_o  <= 1'b0;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      ready_o <= 1'b1;
    end else if (abort_i) begin
      state   <= IDLE;
      iter_o  <= IdxZero;
      load_o  <= 1'b0;
      step_o  <= 1'b0;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      ready_o <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            state   <= LOAD;
            nlat    <= n_clamped;
            iter_o  <= IdxZero;
            load_o  <= 1'b1;
            busy_o  <= 1'b1;
            ready_o <= 1'b0;
          end
        end
        LOAD: begin
          load_o <= 1'b0;
          iter_o <= IdxZero;
          if (nlat == IdxZero) begin
            state   <= DONE;
            valid_o <= 1'b1;
          end else begin
            state  <= RUN;
            step_o <= 1'b1;
          end
        end
        RUN: begin
          // Last micro-rotation: hand over to DONE and park the index at 0.
          if (iter_o == nlat - IdxOne) begin
            state   <= DONE;
            step_o  <= 1'b0;
            iter_o  <= IdxZero;
            valid_o <= 1'b1;
          end else begin
            iter_o <= iter_o + IdxOne;
          end
        end
        DONE: begin
          if (ready_i) begin
            state   <= IDLE;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            ready_o <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          iter_o  <= IdxZero;
          load_o  <= 1'b0;
          step_o  <= 1'b0;
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Self-checking bench for cordic_iter_ctrl: per-operation expectations are queued
// at stimulus time and compared when the monitor sees the operation end.
module tb_cordic_iter_ctrl;

  localparam int unsigned Iterations = 16;
  localparam int unsigned IdxWidth   = 5;

  logic                clk;
  logic                rst_i;
  logic                start_i;
  logic [IdxWidth-1:0] n_i;
  logic                ready_o;
  logic                abort_i;
  logic                load_o;
  logic                step_o;
  logic [IdxWidth-1:0] iter_o;
  logic                busy_o;
  logic                valid_o;
  logic                ready_i;

  typedef struct {
    int steps;
    int vcyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  cordic_iter_ctrl #(
    .Iterations(Iterations),
    .IdxWidth  (IdxWidth)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .start_i(start_i),
    .n_i    (n_i),
    .ready_o(ready_o),
    .abort_i(abort_i),
    .load_o (load_o),
    .step_o (step_o),
    .iter_o (iter_o),
    .busy_o (busy_o),
    .valid_o(valid_o),
    .ready_i(ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: samples at negedge, tracks one operation from load_o to the return of ready_o.
  bit in_op = 1'b0;
  int steps = 0;
  int vcyc  = 0;
  always @(negedge clk) begin
    if (!rst_i) begin
      if (!in_op) begin
        if (load_o) begin
          in_op = 1'b1;
          steps = 0;
          vcyc  = 0;
          chk("load_iter", int'(iter_o), 0);
          chk("load_ready", int'(ready_o), 0);
          chk("load_busy", int'(busy_o), 1);
        end else begin
          chk("idle_quiet", int'({step_o, valid_o, busy_o, ready_o}), 1);
        end
      end else if (ready_o) begin
        in_op = 1'b0;
        chk("end_quiet", int'({load_o, step_o, valid_o, busy_o}), 0);
        if (sb.size() == 0) begin
          chk("sb_underflow", sb.size(), 1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("op_steps", steps, e.steps);
          chk("op_valid_cycles", vcyc, e.vcyc);
        end
      end else begin
        chk("run_busy", int'(busy_o), 1);
        chk("no_reload", int'(load_o), 0);
        chk("step_valid_excl", int'(step_o & valid_o), 0);
        if (step_o) begin
          chk("iter_seq", int'(iter_o), steps);
          steps++;
        end else begin
          chk("iter_zero", int'(iter_o), 0);
        end
        if (valid_o) vcyc++;
      end
    end
  end

  task automatic wait_idle(input string tag);
    int cnt;
    cnt = 0;
    while (!ready_o && cnt < 80) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk(tag, int'(ready_o), 1);
  endtask

  // One operation from IDLE; bp = cycles ready_i stays low after valid_o rises.
  task automatic run_op(input int n, input int bp);
    int nl;
    int cyc;
    nl = (n > int'(Iterations)) ? int'(Iterations) : n;
    sb.push_back('{nl, bp + 1});
    ready_i = (bp == 0);
    @(posedge clk); #1;
    start_i = 1'b1;
    n_i     = IdxWidth'(n);
    @(posedge clk); #1;
    start_i = 1'b0;
    cyc     = 1;
    while (!valid_o && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("valid_lat", cyc, nl + 2);
    if (bp > 0) begin
      repeat (bp) begin
        @(posedge clk); #1;
        cyc++;
        chk("bp_valid_hold", int'(valid_o), 1);
      end
      ready_i = 1'b1;
    end
    while (!ready_o && cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("ready_lat", cyc, nl + 3 + bp);
  endtask

  initial begin
    int cyc;
    rst_i   = 1'b1;
    start_i = 1'b0;
    n_i     = '0;
    abort_i = 1'b0;
    ready_i = 1'b1;
    #12;
    chk("rst_outputs", int'({load_o, step_o, valid_o, busy_o, ready_o}), 1);
    chk("rst_iter", int'(iter_o), 0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", int'(ready_o), 1);

    // Full-depth, zero-count and clamped operations.
    run_op(16, 0);
    run_op(0, 0);
    run_op(20, 0);
    run_op(7, 0);

    // Backpressure on the result handshake.
    run_op(4, 5);

    // Abort at index 7, then a short operation.
    sb.push_back('{8, 0});
    ready_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b1;
    n_i     = IdxWidth'(10);
    @(posedge clk); #1;
    start_i = 1'b0;
    cyc = 1;
    while (iter_o != IdxWidth'(7) && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("abort_reach", int'(iter_o), 7);
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    chk("abort_step", int'(step_o), 0);
    chk("abort_iter", int'(iter_o), 0);
    chk("abort_valid", int'(valid_o), 0);
    chk("abort_ready", int'(ready_o), 1);
    // Abort in IDLE beats a simultaneous start.
    abort_i = 1'b1;
    start_i = 1'b1;
    n_i     = IdxWidth'(5);
    @(posedge clk); #1;
    abort_i = 1'b0;
    start_i = 1'b0;
    chk("abort_idle_load", int'(load_o), 0);
    chk("abort_idle_ready", int'(ready_o), 1);
    run_op(3, 0);

    // start_i held through RUN and DONE with a different count.
    sb.push_back('{5, 1});
    sb.push_back('{9, 1});
    ready_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b1;
    n_i     = IdxWidth'(5);
    @(posedge clk); #1;
    n_i = IdxWidth'(9);
    repeat (8) begin
      @(posedge clk); #1;
    end
    chk("hold_reload", int'(load_o), 1);
    start_i = 1'b0;
    wait_idle("hold_idle");

    // Asynchronous reset while iter_o is 9.
    sb.push_back('{10, 0});
    @(posedge clk); #1;
    start_i = 1'b1;
    n_i     = IdxWidth'(12);
    @(posedge clk); #1;
    start_i = 1'b0;
    cyc = 1;
    while (iter_o != IdxWidth'(9) && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rst_reach", int'(iter_o), 9);
    @(negedge clk); #2;
    rst_i = 1'b1;
    #1;
    chk("async_rst_outputs", int'({load_o, step_o, valid_o, busy_o, ready_o}), 1);
    chk("async_rst_iter", int'(iter_o), 0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    run_op(2, 0);

    repeat (3) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
